// File: rtl/dps_enc_arbiter_if.sv
// Requester, encoder and code-output signals of the shared-encoder arbiter.
// The slave side is the arbiter; the master side is the surrounding logic.
interface dps_enc_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DLEN = 29,
   parameter int unsigned CLEN = 42,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic [DLEN-1:0]      enc_datain;
   logic [CLEN-1:0]      enc_codein;
   logic                 code_valid;
   logic [CLEN-1:0]      code_data;
   logic [IDW-1:0]       code_id;
   logic                 code_ready;
   logic                 busy;

   modport master (
      output req_valid, req_data, enc_codein, code_ready,
      input  req_ready, enc_datain, code_valid, code_data, code_id, busy
   );

   modport slave (
      input  req_valid, req_data, enc_codein, code_ready,
      output req_ready, enc_datain, code_valid, code_data, code_id, busy
   );
endinterface

// File: rtl/dps_enc_arbiter.sv
// Round-robin sharing of one external registered encoder between NREQ requesters,
// with id tagging through the encoder latency and a credit-guarded show-ahead output FIFO.
module dps_enc_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DLEN    = 29,
   parameter int unsigned CLEN    = 42,
   parameter int unsigned ENC_LAT = 1,
   parameter int unsigned ODEPTH  = 4,
   parameter int unsigned IDW     = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   dps_enc_arbiter_if.slave  bus
);
   localparam int unsigned AW = $clog2(ODEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(ODEPTH + 1);
   localparam int unsigned NS = ENC_LAT + 1;
   localparam int unsigned EW = IDW + CLEN;

   logic [IDW-1:0]          ptr_q, ptr_d;
   logic [CW-1:0]           credits_q, credits_d;
   logic [DLEN-1:0]         enc_q, enc_d;
   logic [NS-1:0]           pv_q, pv_d;
   logic [NS-1:0][IDW-1:0]  pid_q, pid_d;
   logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [EW-1:0]           mem [ODEPTH];
   logic                    ov_q, ov_d;
   logic [CLEN-1:0]         od_q, od_d;
   logic [IDW-1:0]          oid_q, oid_d;
   logic                    busy_q, busy_d;

   logic [NREQ-1:0]         grant;
   logic [IDW-1:0]          gidx, sidx;
   logic [DLEN-1:0]         gdata;
   logic                    found, issue, pop, wr, out_free, mem_empty, mem_full, mem_we;
   int unsigned             scan;

   // Round-robin scan from ptr; reset and exhausted credits both suppress the grant.
   always_comb begin
      grant = '0;
      gidx  = '0;
      sidx  = '0;
      found = 1'b0;
      scan  = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan = 32'(ptr_q) + k;
         if (scan >= NREQ) scan = scan - NREQ;
         sidx = IDW'(scan);
         if (!found && bus.req_valid[sidx]) begin
            found = 1'b1;
            gidx  = sidx;
         end
      end
      if (found && rst_n && (credits_q != '0)) grant[gidx] = 1'b1;
   end

   always_comb begin
      gdata = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         if (gidx == IDW'(i)) gdata = bus.req_data[i*DLEN +: DLEN];
   end

   assign issue     = |grant;
   assign pop       = ov_q & bus.code_ready;
   assign out_free  = ~ov_q | pop;
   assign wr        = pv_q[NS-1];
   assign mem_empty = (wptr_q == rptr_q);
   assign mem_full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

   always_comb begin
      ptr_d     = ptr_q;
      enc_d     = enc_q;
      credits_d = credits_q - CW'(issue) + CW'(pop);
      pv_d      = '0;
      pid_d     = '0;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      ov_d      = ov_q;
      od_d      = od_q;
      oid_d     = oid_q;
      mem_we    = 1'b0;

      if (issue) begin
         ptr_d = ((32'(gidx) + 1) >= NREQ) ? '0 : gidx + IDW'(1);
         enc_d = gdata;
      end

      // Stage 0 lines up with enc_datain; the tail lines up with enc_codein.
      pv_d[0]  = issue;
      pid_d[0] = gidx;
      for (int unsigned s = 1; s < NS; s++) begin
         pv_d[s]  = pv_q[s-1];
         pid_d[s] = pid_q[s-1];
      end

      // Output register refills from the FIFO, or straight from the encoder when empty.
      if (out_free) begin
         if (!mem_empty) begin
            ov_d          = 1'b1;
            {oid_d, od_d} = mem[rptr_q[AW-1:0]];
            rptr_d        = rptr_q + PW'(1);
         end else if (wr) begin
            ov_d  = 1'b1;
            od_d  = bus.enc_codein;
            oid_d = pid_q[NS-1];
         end else begin
            ov_d  = 1'b0;
         end
      end

      if (wr && !(out_free && mem_empty) && !mem_full) begin
         mem_we = 1'b1;
         wptr_d = wptr_q + PW'(1);
      end

      busy_d = (|pv_d) | (wptr_d != rptr_d) | ov_d;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         credits_q <= CW'(ODEPTH);
         enc_q     <= '0;
         pv_q      <= '0;
         pid_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         ov_q      <= 1'b0;
         od_q      <= '0;
         oid_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         credits_q <= credits_d;
         enc_q     <= enc_d;
         pv_q      <= pv_d;
         pid_q     <= pid_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ov_q      <= ov_d;
         od_q      <= od_d;
         oid_q     <= oid_d;
         busy_q    <= busy_d;
      end
   end

   // Storage array needs no reset: only entries between rptr and wptr are ever read.
   always_ff @(posedge clock) begin
      if (mem_we) mem[wptr_q[AW-1:0]] <= {pid_q[NS-1], bus.enc_codein};
   end

   assign bus.req_ready  = grant;
   assign bus.enc_datain = enc_q;
   assign bus.code_valid = ov_q;
   assign bus.code_data  = od_q;
   assign bus.code_id    = oid_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dps_enc_arbiter.sv
// Bench for dps_enc_arbiter: stand-in encoder, queue-based reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_dps_enc_arbiter;
   localparam int NREQ = 4;
   localparam int DLEN = 29;
   localparam int CLEN = 42;
   localparam int ODEPTH = 4;
   localparam int LAT_OUT = 3;  // accept cycle to first code_valid cycle (ENC_LAT + 2)
   localparam logic [DLEN-1:0] DMAX = 29'h1FFF_FFFF;

   typedef struct {
      int             id;
      logic [DLEN-1:0] d;
      int             t;
   } ent_t;

   logic clock = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   cyc_n = 0;

   dps_enc_arbiter_if #(.NREQ(4), .DLEN(29), .CLEN(42), .IDW(2)) bus ();

   dps_enc_arbiter #(.NREQ(4), .DLEN(29), .CLEN(42), .ENC_LAT(1), .ODEPTH(4), .IDW(2)) dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [CLEN-1:0] enc_f(input logic [DLEN-1:0] d);
      return {d[12:0], d};
   endfunction

   function automatic logic [DLEN-1:0] lane(input logic [NREQ*DLEN-1:0] v, input int i);
      logic [NREQ*DLEN-1:0] sh;
      sh = v >> (i * DLEN);
      return sh[DLEN-1:0];
   endfunction

   // Stand-in for the external registered encoder (one cycle of latency).
   always @(posedge clock) bus.enc_codein <= enc_f(bus.enc_datain);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc_n, act, exp);
      end
   endtask

   ent_t            exp_q[$];
   int              m_ptr = 0;
   logic [DLEN-1:0] m_last = '0;
   int              dut_out = 0;
   int              g_ids[$], g_cyc[$], p_ids[$], p_cyc[$];
   logic [CLEN-1:0] p_code[$];
   logic [NREQ-1:0] eg;
   int              gi, jj, dacc, dpop;
   logic            ev;
   ent_t            ne;

   // Reference model: words leave in acceptance order, each no earlier than LAT_OUT cycles
   // after acceptance; grants follow round-robin while fewer than ODEPTH words are outstanding.
   always @(negedge clock) begin
      cyc_n = cyc_n + 1;
      if (!rst_n) begin
         chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
         chk("rst_enc_datain", 64'(bus.enc_datain), 64'd0);
         chk("rst_code_valid", 64'(bus.code_valid), 64'd0);
         chk("rst_code_data", 64'(bus.code_data), 64'd0);
         chk("rst_code_id", 64'(bus.code_id), 64'd0);
         chk("rst_busy", 64'(bus.busy), 64'd0);
         exp_q.delete();
         m_ptr = 0;
         m_last = '0;
         dut_out = 0;
      end else begin
         eg = '0;
         gi = -1;
         if (exp_q.size() < ODEPTH)
            for (int k = 0; k < NREQ; k++) begin
               jj = (m_ptr + k) % NREQ;
               if (gi < 0 && bus.req_valid[2'(jj)]) gi = jj;
            end
         if (gi >= 0) eg = 4'(1 << gi);
         ev = (exp_q.size() != 0) && (exp_q[0].t + LAT_OUT <= cyc_n);

         chk("req_ready", 64'(bus.req_ready), 64'(eg));
         chk("enc_datain", 64'(bus.enc_datain), 64'(m_last));
         chk("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
         chk("code_valid", 64'(bus.code_valid), 64'(ev));
         if (ev) begin
            chk("code_data", 64'(bus.code_data), 64'(enc_f(exp_q[0].d)));
            chk("code_id", 64'(bus.code_id), 64'(exp_q[0].id));
         end

         dacc = ((bus.req_valid & bus.req_ready) != '0) ? 1 : 0;
         dpop = (bus.code_valid && bus.code_ready) ? 1 : 0;
         dut_out = dut_out + dacc - dpop;
         chk("no_overflow", 64'(dut_out <= ODEPTH && dut_out >= 0), 64'd1);

         if (dpop != 0) begin
            p_ids.push_back(int'(bus.code_id));
            p_cyc.push_back(cyc_n);
            p_code.push_back(bus.code_data);
         end
         for (int i = 0; i < NREQ; i++)
            if (bus.req_valid[2'(i)] && bus.req_ready[2'(i)]) begin
               g_ids.push_back(i);
               g_cyc.push_back(cyc_n);
            end

         if (ev && bus.code_ready) void'(exp_q.pop_front());
         if (gi >= 0) begin
            ne.id = gi;
            ne.d  = lane(bus.req_data, gi);
            ne.t  = cyc_n;
            exp_q.push_back(ne);
            m_ptr  = (gi + 1) % NREQ;
            m_last = ne.d;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_rand();
      for (int i = 0; i < NREQ; i++) bus.req_data[i*DLEN +: DLEN] = DLEN'($urandom);
   endtask

   task automatic clear_logs();
      g_ids.delete(); g_cyc.delete(); p_ids.delete(); p_cyc.delete(); p_code.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 4'hF;
      bus.code_ready = 1'b1;
      drive_rand();
      repeat (4) step();

      // Release with all requesters valid: round-robin from requester 0
      rst_n = 1'b1;
      clear_logs();
      @(negedge clock);
      chk("first_grant", 64'(bus.req_ready), 64'h1);
      repeat (7) begin step(); drive_rand(); end
      step();
      bus.req_valid = '0;
      repeat (6) step();
      chk("rr_grant_count", 64'(g_ids.size()), 64'd8);
      chk("rr_pop_count", 64'(p_ids.size()), 64'd8);
      for (int i = 0; i < 8 && i < g_ids.size(); i++) chk("rr_grant_id", 64'(g_ids[i]), 64'(i % 4));
      for (int i = 0; i < 8 && i < p_ids.size(); i++) chk("rr_code_id", 64'(p_ids[i]), 64'(i % 4));
      if (g_cyc.size() > 0 && p_cyc.size() > 0)
         chk("first_code_latency", 64'(p_cyc[0] - g_cyc[0]), 64'd3);

      // Back-pressure: only ODEPTH words accepted, then pop at full with no same-cycle grant
      clear_logs();
      bus.code_ready = 1'b0;
      bus.req_valid = 4'hF;
      repeat (8) begin drive_rand(); step(); end
      chk("bp_accept_count", 64'(g_ids.size()), 64'd4);
      bus.code_ready = 1'b1;
      @(negedge clock);
      chk("full_pop_no_grant", 64'(bus.req_ready), 64'd0);
      chk("full_pop_valid", 64'(bus.code_valid), 64'd1);
      step();
      bus.code_ready = 1'b0;
      @(negedge clock);
      chk("after_pop_one_grant", 64'($countones(bus.req_ready)), 64'd1);
      step();
      bus.req_valid = '0;
      bus.code_ready = 1'b1;
      repeat (10) step();
      chk("bp_total_grants", 64'(g_ids.size()), 64'd5);
      chk("bp_total_pops", 64'(p_ids.size()), 64'd5);
      for (int i = 0; i < 5 && i < p_ids.size(); i++) chk("bp_order_id", 64'(p_ids[i]), 64'(i % 4));

      // Encoding corner values through requester 2
      clear_logs();
      bus.req_valid = 4'b0100;
      bus.req_data[2*DLEN +: DLEN] = '0;
      step();
      bus.req_data[2*DLEN +: DLEN] = 29'd1;
      step();
      bus.req_data[2*DLEN +: DLEN] = DMAX;
      step();
      bus.req_valid = '0;
      repeat (6) step();
      chk("enc_pop_count", 64'(p_code.size()), 64'd3);
      if (p_code.size() == 3) begin
         chk("enc_code_zero", 64'(p_code[0]), 64'd0);
         chk("enc_code_one", 64'(p_code[1]), 64'h000_2000_0001);
         chk("enc_code_max", 64'(p_code[2]), 64'h3FF_FFFF_FFFF);
         for (int i = 0; i < 3; i++) chk("enc_code_id", 64'(p_ids[i]), 64'd2);
      end

      // Reset with words in flight and buffered: none may emerge afterwards
      clear_logs();
      bus.code_ready = 1'b0;
      bus.req_valid = 4'hF;
      repeat (3) begin drive_rand(); step(); end
      bus.req_valid = '0;
      chk("mid_accepts", 64'(g_ids.size()), 64'd3);
      step();
      rst_n = 1'b0;
      @(negedge clock);
      chk("mid_rst_code_valid", 64'(bus.code_valid), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      bus.code_ready = 1'b1;
      clear_logs();
      @(negedge clock);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      repeat (8) step();
      chk("post_rst_no_codes", 64'(p_ids.size()), 64'd0);
      bus.req_valid = 4'b1000;
      bus.req_data[3*DLEN +: DLEN] = 29'h0ABC_DEF;
      step();
      bus.req_valid = '0;
      repeat (5) step();
      chk("post_rst_pop_count", 64'(p_ids.size()), 64'd1);
      if (p_ids.size() == 1) begin
         chk("post_rst_id", 64'(p_ids[0]), 64'd3);
         chk("post_rst_code", 64'(p_code[0]), 64'(enc_f(29'h0ABC_DEF)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
